wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter.sv | 116 +++++++++++
 tb/tb_wb_arbiter.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: two-source writeback arbiter with per-source FIFOs and a registered broadcast bus;
// define WB_ARB_ROUND_ROBIN_EN for round-robin contention, otherwise lsb has fixed priority.
module wb_arbiter #(
    parameter int ROB_ID_W = 4,
    parameter int XLEN     = 32,
    parameter int DEPTH    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rdy,
    input  logic                reset_from_rob_bus,
    input  logic                rss_valid,
    output logic                rss_ready,
    input  logic [ROB_ID_W-1:0] rss_dest,
    input  logic [XLEN-1:0]     rss_value,
    input  logic [XLEN-1:0]     rss_next_pc,
    input  logic                lsb_valid,
    output logic                lsb_ready,
    input  logic [ROB_ID_W-1:0] lsb_dest,
    input  logic [XLEN-1:0]     lsb_value,
    output logic [ROB_ID_W-1:0] wb_dest,
    output logic [XLEN-1:0]     wb_value,
    output logic [XLEN-1:0]     wb_next_pc,
    output logic                wb_src
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [ROB_ID_W-1:0] rss_dest_q [DEPTH];
    logic [XLEN-1:0]     rss_value_q [DEPTH];
    logic [XLEN-1:0]     rss_npc_q [DEPTH];
    logic [ROB_ID_W-1:0] lsb_dest_q [DEPTH];
    logic [XLEN-1:0]     lsb_value_q [DEPTH];
    logic [AW-1:0]       rss_head, rss_tail, lsb_head, lsb_tail;
    logic [CW-1:0]       rss_cnt, lsb_cnt;
    logic                rss_push, lsb_push, gnt_rss, gnt_lsb, open;
`ifdef WB_ARB_ROUND_ROBIN_EN
    logic                rr;
`endif

    always_comb begin
        open      = rdy && rst && !reset_from_rob_bus;
        rss_ready = open && (rss_cnt < CW'(DEPTH));
        lsb_ready = open && (lsb_cnt < CW'(DEPTH));
        // dest 0 is handshaken but never enqueued
        rss_push  = rss_valid && rss_ready && (rss_dest != '0);
        lsb_push  = lsb_valid && lsb_ready && (lsb_dest != '0);
`ifdef WB_ARB_ROUND_ROBIN_EN
        gnt_lsb   = (lsb_cnt != '0) && ((rss_cnt == '0) || rr);
`else
        gnt_lsb   = lsb_cnt != '0;
`endif
        gnt_rss   = (rss_cnt != '0) && !gnt_lsb;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rss_head   <= '0;
            rss_tail   <= '0;
            rss_cnt    <= '0;
            lsb_head   <= '0;
            lsb_tail   <= '0;
            lsb_cnt    <= '0;
            wb_dest    <= '0;
            wb_value   <= '0;
            wb_next_pc <= '0;
            wb_src     <= 1'b0;
`ifdef WB_ARB_ROUND_ROBIN_EN
            rr         <= 1'b0;
`endif
        end else if (rdy && reset_from_rob_bus) begin
            rss_head <= '0;
            rss_tail <= '0;
            rss_cnt  <= '0;
            lsb_head <= '0;
            lsb_tail <= '0;
            lsb_cnt  <= '0;
            wb_dest  <= '0;
        end else if (rdy) begin
            if (rss_push) begin
                rss_dest_q[rss_tail]  <= rss_dest;
                rss_value_q[rss_tail] <= rss_value;
                rss_npc_q[rss_tail]   <= rss_next_pc;
                rss_tail              <= rss_tail + 1'b1;
            end
            if (lsb_push) begin
                lsb_dest_q[lsb_tail]  <= lsb_dest;
                lsb_value_q[lsb_tail] <= lsb_value;
                lsb_tail              <= lsb_tail + 1'b1;
            end
            if (gnt_rss)
                rss_head <= rss_head + 1'b1;
            if (gnt_lsb)
                lsb_head <= lsb_head + 1'b1;
            rss_cnt <= rss_cnt + CW'(rss_push) - CW'(gnt_rss);
            lsb_cnt <= lsb_cnt + CW'(lsb_push) - CW'(gnt_lsb);
            if (gnt_lsb) begin
                wb_dest    <= lsb_dest_q[lsb_head];
                wb_value   <= lsb_value_q[lsb_head];
                wb_next_pc <= '0;
                wb_src     <= 1'b1;
            end else if (gnt_rss) begin
                wb_dest    <= rss_dest_q[rss_head];
                wb_value   <= rss_value_q[rss_head];
                wb_next_pc <= rss_npc_q[rss_head];
                wb_src     <= 1'b0;
            end else begin
                wb_dest <= '0;
            end
`ifdef WB_ARB_ROUND_ROBIN_EN
            if ((rss_cnt != '0) && (lsb_cnt != '0))
                rr <= !gnt_lsb;
`endif
        end
    end
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed checks of wb_arbiter (fixed priority, or round-robin with WB_ARB_ROUND_ROBIN_EN).
module tb_wb_arbiter;
    logic        clk = 1'b0;
    logic        rst, rdy, reset_from_rob_bus;
    logic        rss_valid, rss_ready, lsb_valid, lsb_ready;
    logic [3:0]  rss_dest, lsb_dest, wb_dest;
    logic [31:0] rss_value, rss_next_pc, lsb_value, wb_value, wb_next_pc;
    logic        wb_src;
    int          vectors = 0;
    int          errs = 0;
    logic [3:0]  seen [$];
    logic [3:0]  exp_q [$];

    wb_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy), .reset_from_rob_bus(reset_from_rob_bus),
        .rss_valid(rss_valid), .rss_ready(rss_ready), .rss_dest(rss_dest),
        .rss_value(rss_value), .rss_next_pc(rss_next_pc),
        .lsb_valid(lsb_valid), .lsb_ready(lsb_ready), .lsb_dest(lsb_dest), .lsb_value(lsb_value),
        .wb_dest(wb_dest), .wb_value(wb_value), .wb_next_pc(wb_next_pc), .wb_src(wb_src)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        if (wb_dest != 4'd0)
            seen.push_back(wb_dest);
    endtask

    task automatic chk_seen(input string tag);
        chk({tag, "_len"}, seen.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < seen.size(); i++)
            chk(tag, 32'(seen[i]), 32'(exp_q[i]));
    endtask

    initial begin
        rst = 1'b0; rdy = 1'b1; reset_from_rob_bus = 1'b0;
        rss_valid = 1'b0; rss_dest = '0; rss_value = '0; rss_next_pc = '0;
        lsb_valid = 1'b0; lsb_dest = '0; lsb_value = '0;
        tick();
        tick();
        chk("rst_wb_dest", 32'(wb_dest), 0);
        chk("rst_wb_value", wb_value, 0);
        chk("rst_wb_next_pc", wb_next_pc, 0);
        chk("rst_wb_src", 32'(wb_src), 0);
        chk("rst_rss_ready", 32'(rss_ready), 0);
        chk("rst_lsb_ready", 32'(lsb_ready), 0);
        rst = 1'b1;
        #1;
        chk("rdy_rss_ready", 32'(rss_ready), 1);
        chk("rdy_lsb_ready", 32'(lsb_ready), 1);

        // single rss result, latency of one edge after push
        rss_valid = 1'b1; rss_dest = 4'd3; rss_value = 32'h11; rss_next_pc = 32'h104;
        tick();
        rss_valid = 1'b0;
        chk("t1_not_yet", 32'(wb_dest), 0);
        tick();
        chk("t1_dest", 32'(wb_dest), 3);
        chk("t1_value", wb_value, 32'h11);
        chk("t1_npc", wb_next_pc, 32'h104);
        chk("t1_src", 32'(wb_src), 0);
        tick();
        chk("t1_idle", 32'(wb_dest), 0);
        chk("t1_value_hold", wb_value, 32'h11);

        // simultaneous pushes
        rss_valid = 1'b1; rss_dest = 4'd5; rss_value = 32'h55; rss_next_pc = 32'h200;
        lsb_valid = 1'b1; lsb_dest = 4'd6; lsb_value = 32'h66;
        tick();
        rss_valid = 1'b0; lsb_valid = 1'b0;
        tick();
`ifdef WB_ARB_ROUND_ROBIN_EN
        chk("t2_first", 32'(wb_dest), 5);
        chk("t2_first_npc", wb_next_pc, 32'h200);
        tick();
        chk("t2_second", 32'(wb_dest), 6);
        chk("t2_second_src", 32'(wb_src), 1);
`else
        chk("t2_first", 32'(wb_dest), 6);
        chk("t2_first_src", 32'(wb_src), 1);
        chk("t2_first_npc", wb_next_pc, 0);
        tick();
        chk("t2_second", 32'(wb_dest), 5);
        chk("t2_second_npc", wb_next_pc, 32'h200);
`endif
        tick();
        chk("t2_idle", 32'(wb_dest), 0);

        // sustained contention from reset: rss 1..4, lsb 8..11, honouring ready
        rst = 1'b0;
        tick();
        rst = 1'b1;
        seen.delete();
        begin
            logic [3:0] ri, li;
            logic acc_r, acc_l;
            ri = 4'd1; li = 4'd8;
            for (int c = 0; c < 14; c++) begin
                rss_valid = (ri <= 4'd4); rss_dest = ri; rss_value = 32'(ri); rss_next_pc = 32'(ri) << 4;
                lsb_valid = (li <= 4'd11); lsb_dest = li; lsb_value = 32'(li);
                #1;
                if (c == 2) begin
`ifdef WB_ARB_ROUND_ROBIN_EN
                    chk("t3_lsb_full", 32'(lsb_ready), 0);
                    chk("t3_rss_open", 32'(rss_ready), 1);
`else
                    chk("t3_rss_full", 32'(rss_ready), 0);
                    chk("t3_lsb_open", 32'(lsb_ready), 1);
`endif
                end
                acc_r = rss_valid && rss_ready;
                acc_l = lsb_valid && lsb_ready;
                tick();
                if (acc_r) ri++;
                if (acc_l) li++;
            end
            rss_valid = 1'b0; lsb_valid = 1'b0;
        end
`ifdef WB_ARB_ROUND_ROBIN_EN
        exp_q = '{4'd1, 4'd8, 4'd2, 4'd9, 4'd3, 4'd10, 4'd4, 4'd11};
`else
        exp_q = '{4'd8, 4'd9, 4'd10, 4'd11, 4'd1, 4'd2, 4'd3, 4'd4};
`endif
        chk_seen("t3_order");

        // fill both FIFOs then flush
        rss_valid = 1'b1; rss_dest = 4'd1; lsb_valid = 1'b1; lsb_dest = 4'd3;
        tick();
        rss_dest = 4'd2; lsb_dest = 4'd4;
        tick();
        rss_dest = 4'd13; lsb_dest = 4'd14; reset_from_rob_bus = 1'b1;
        #1;
        chk("t4_flush_rss_ready", 32'(rss_ready), 0);
        chk("t4_flush_lsb_ready", 32'(lsb_ready), 0);
        tick();
        reset_from_rob_bus = 1'b0; rss_valid = 1'b0; lsb_valid = 1'b0;
        #1;
        chk("t4_wb_dest", 32'(wb_dest), 0);
        chk("t4_rss_ready", 32'(rss_ready), 1);
        chk("t4_lsb_ready", 32'(lsb_ready), 1);
        seen.delete();
        for (int c = 0; c < 5; c++) tick();
        exp_q.delete();
        chk_seen("t4_stale");

        // rdy freeze
        rss_valid = 1'b1; rss_dest = 4'd6; rss_value = 32'h66; rss_next_pc = 32'h10;
        tick();
        rss_dest = 4'd7; rss_value = 32'h77; rss_next_pc = 32'h300;
        tick();
        rss_valid = 1'b0; rdy = 1'b0;
        #1;
        chk("t5_rss_ready", 32'(rss_ready), 0);
        chk("t5_lsb_ready", 32'(lsb_ready), 0);
        for (int c = 0; c < 3; c++) begin
            tick();
            chk("t5_frozen_dest", 32'(wb_dest), 6);
            chk("t5_frozen_value", wb_value, 32'h66);
        end
        rdy = 1'b1;
        tick();
        chk("t5_dest", 32'(wb_dest), 7);
        chk("t5_value", wb_value, 32'h77);
        chk("t5_npc", wb_next_pc, 32'h300);
        tick();
        chk("t5_idle", 32'(wb_dest), 0);

        // dest 0 accepted and dropped
        rss_valid = 1'b1; rss_dest = 4'd0; lsb_valid = 1'b1; lsb_dest = 4'd0;
        #1;
        chk("t6_rss_ready", 32'(rss_ready), 1);
        seen.delete();
        tick();
        rss_valid = 1'b0; lsb_valid = 1'b0;
        #1;
        chk("t6_rss_ready_after", 32'(rss_ready), 1);
        chk("t6_lsb_ready_after", 32'(lsb_ready), 1);
        for (int c = 0; c < 3; c++) tick();
        chk_seen("t6_dropped");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
